star_box_draw: RTL

Downstream stage of the left/right edge finders. Captures the `mostLeft`/`leftFound` and `mostRight`/`rightFound` results, and samples `mostTop`/`mostBottom` from the top/bottom mapper. It then draws a one-pixel rectangular outline around the detected star, using the VGA adapter plot interface (one pixel per cycle). When the outline is complete it emits a single-cycle `drawDone` pulse to the top-level controller.

---
 rtl/star_box_draw.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/star_box_draw.sv
// Draws a one-pixel rectangular outline around the detected star, one pixel per cycle,
// from captured left/right edges and the sampled top/bottom rows.
module star_box_draw #(
    parameter int               xSz        = 8,
    parameter int               ySz        = 7,
    parameter int               colSz      = 3,
    parameter logic [colSz-1:0] BOX_COLOUR = 3'b100
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             leftFound,
    input  logic [xSz-1:0]   mostLeft,
    input  logic             rightFound,
    input  logic [xSz-1:0]   mostRight,
    input  logic [ySz-1:0]   mostTop,
    input  logic [ySz-1:0]   mostBottom,
    output logic [xSz-1:0]   x,
    output logic [ySz-1:0]   y,
    output logic [colSz-1:0] colour,
    output logic             plot,
    output logic             busy,
    output logic             drawDone
);

    typedef enum logic [2:0] {IDLE, LOAD, TOP, BOT, LEFT, RIGHT, DONE} state_t;

    state_t           state_q, state_d;
    logic             got_l_q, got_l_d, got_r_q, got_r_d;
    logic [xSz-1:0]   l_q, l_d, r_q, r_d;
    logic [ySz-1:0]   t_q, t_d, b_q, b_d;
    logic [xSz-1:0]   x_q, x_d;
    logic [ySz-1:0]   y_q, y_d;
    logic [colSz-1:0] colour_q, colour_d;
    logic             plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    // x_q/y_q double as the walk counters: while drawing they always hold the
    // pixel currently on the bus, so the end-of-edge compare happens before increment.
    always_comb begin
        state_d  = state_q;
        got_l_d  = got_l_q;
        got_r_d  = got_r_q;
        l_d      = l_q;
        r_d      = r_q;
        t_d      = t_q;
        b_d      = b_q;
        x_d      = x_q;
        y_d      = y_q;
        plot_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (leftFound) begin
                    got_l_d = 1'b1;
                    l_d     = mostLeft;
                end
                if (rightFound) begin
                    got_r_d = 1'b1;
                    r_d     = mostRight;
                end
                if (got_l_d && got_r_d) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            LOAD: begin
                got_l_d = 1'b0;
                got_r_d = 1'b0;
                t_d     = mostTop;
                b_d     = mostBottom;
                if (r_q < l_q || mostBottom < mostTop) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = TOP;
                    plot_d  = 1'b1;
                    x_d     = l_q;
                    y_d     = mostTop;
                end
            end
            TOP: begin
                plot_d = 1'b1;
                if (x_q == r_q) begin
                    state_d = BOT;
                    x_d     = l_q;
                    y_d     = b_q;
                end else begin
                    x_d = x_q + xSz'(1);
                end
            end
            BOT: begin
                plot_d = 1'b1;
                if (x_q == r_q) begin
                    state_d = LEFT;
                    x_d     = l_q;
                    y_d     = t_q;
                end else begin
                    x_d = x_q + xSz'(1);
                end
            end
            LEFT: begin
                plot_d = 1'b1;
                if (y_q == b_q) begin
                    state_d = RIGHT;
                    x_d     = r_q;
                    y_d     = t_q;
                end else begin
                    y_d = y_q + ySz'(1);
                end
            end
            RIGHT: begin
                if (y_q == b_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    plot_d = 1'b1;
                    y_d    = y_q + ySz'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        colour_d = plot_d ? BOX_COLOUR : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            got_l_q  <= 1'b0;
            got_r_q  <= 1'b0;
            l_q      <= '0;
            r_q      <= '0;
            t_q      <= '0;
            b_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            got_l_q  <= got_l_d;
            got_r_q  <= got_r_d;
            l_q      <= l_d;
            r_q      <= r_d;
            t_q      <= t_d;
            b_q      <= b_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign colour   = colour_q;
    assign plot     = plot_q;
    assign busy     = busy_q;
    assign drawDone = done_q;

endmodule
